// File: rtl/mem_rd_pkg.sv
// Shared constants and the request tag carried alongside read data
// through the mem_rd_responder pipeline.
package mem_rd_pkg;

  localparam int MEM_RD_ADDR_W  = 8;
  localparam int MEM_RD_LAT_MAX = 4;
  localparam int MEM_RD_CNT_W   = 16;

  typedef struct packed {
    logic valid;
    logic err;
  } mem_rd_tag_t;

endpackage

// File: rtl/type_i_mem_rd.sv
// Read request/response bundle: the master drives addr/read, and the
// slave answers with data/valid after its own fixed latency.
interface type_i_mem_rd
  import mem_rd_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic [MEM_RD_ADDR_W-1:0] addr;
  logic                     read;
  logic [WIDTH-1:0]         data;
  logic                     valid;

  modport master (output addr, output read, input data, input valid);
  modport slave  (input addr, input read, output data, output valid);

endinterface

// File: rtl/mem_rd_delay_line.sv
// Fixed-length shift register. Only the valid bits are reset; the payload
// is qualified downstream by its valid bit.
module mem_rd_delay_line #(
  parameter int STAGES = 1,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  output logic [W-1:0] data_out
);

  logic [STAGES-1:0] valid_r;
  logic [W-1:0]      data_r [STAGES];

  // Valid bits shift every cycle and are cleared by reset.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      valid_r <= {STAGES{1'b0}};
    end else begin
      valid_r[0] <= valid_in;
      for (int i = 1; i < STAGES; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  // Payload shifts with no reset.
  always_ff @(posedge clk) begin
    data_r[0] <= data_in;
    for (int i = 1; i < STAGES; i++) begin
      data_r[i] <= data_r[i-1];
    end
  end

  assign valid_out = valid_r[STAGES-1];
  assign data_out  = data_r[STAGES-1];

endmodule

// File: rtl/mem_rd_responder.sv
// Fixed-latency memory slave for type_i_mem_rd: one read per clock, no stall,
// read-first on address collisions, zero data with addr_err for out-of-range reads.
module mem_rd_responder
  import mem_rd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset_p,
  type_i_mem_rd.slave              rd,
  input  logic                     wr_en,
  input  logic [MEM_RD_ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [MEM_RD_CNT_W-1:0]  rd_count,
  output logic                     addr_err
);

  localparam logic [MEM_RD_ADDR_W:0] DEPTH_L = (MEM_RD_ADDR_W+1)'(DEPTH);

  if (DEPTH < 1 || DEPTH > 256) begin : g_depth_chk
    $error("mem_rd_responder: DEPTH must be within 1..256");
  end
  if (LATENCY < 1 || LATENCY > MEM_RD_LAT_MAX) begin : g_lat_chk
    $error("mem_rd_responder: LATENCY must be within 1..4");
  end

  logic [WIDTH-1:0]        mem_r [DEPTH];
  logic                    rd_in_range_s;
  logic                    wr_in_range_s;
  mem_rd_tag_t             tag0_r;
  logic [WIDTH-1:0]        data0_r;
  mem_rd_tag_t             tag_out_s;
  logic [WIDTH-1:0]        data_out_s;
  logic [MEM_RD_CNT_W-1:0] count_r;

  // Address range decode for both ports; 9-bit compare so DEPTH=256 works.
  always_comb begin
    rd_in_range_s = ({1'b0, rd.addr} < DEPTH_L);
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
  end

  // Memory array, deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Memory output register: first pipeline stage, and read-first by construction.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      tag0_r  <= 2'b00;
      data0_r <= {WIDTH{1'b0}};
    end else begin
      tag0_r.valid <= rd.read;
      tag0_r.err   <= rd.read && !rd_in_range_s;
      if (rd.read && rd_in_range_s) begin
        data0_r <= mem_r[rd.addr];
      end else begin
        data0_r <= {WIDTH{1'b0}};
      end
    end
  end

  // Accepted-read counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      count_r <= {MEM_RD_CNT_W{1'b0}};
    end else if (rd.read && (count_r != {MEM_RD_CNT_W{1'b1}})) begin
      count_r <= count_r + MEM_RD_CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign tag_out_s  = tag0_r;
    assign data_out_s = data0_r;
  end else begin : g_pipe
    logic [WIDTH:0] pay_in_s;
    logic [WIDTH:0] pay_out_s;
    logic           valid_out_s;

    assign pay_in_s = {tag0_r.err, data0_r};

    mem_rd_delay_line #(
      .STAGES (LATENCY - 1),
      .W      (WIDTH + 1)
    ) u_delay (
      .clk       (clk),
      .reset_p   (reset_p),
      .valid_in  (tag0_r.valid),
      .data_in   (pay_in_s),
      .valid_out (valid_out_s),
      .data_out  (pay_out_s)
    );

    assign tag_out_s.valid = valid_out_s;
    assign tag_out_s.err   = pay_out_s[WIDTH];
    assign data_out_s      = pay_out_s[WIDTH-1:0];
  end

  // Output select: unreset payload never leaks out while valid is low.
  always_comb begin
    if (tag_out_s.valid) begin
      rd.valid = 1'b1;
      rd.data  = data_out_s;
      addr_err = tag_out_s.err;
    end else begin
      rd.valid = 1'b0;
      rd.data  = {WIDTH{1'b0}};
      addr_err = 1'b0;
    end
  end

  assign rd_count = count_r;

endmodule
